// File: rtl/seven_seg_arbiter_if.sv
// seven_seg_arbiter_if: bundle between display requesters and the arbiter.
//   req       - per-requester display request, level-sensitive
//   data      - packed requester values, requester i at data[16*i +: 16]
//   lock      - pins the current owner while high
//   grant     - one-hot current owner, zero when idle
//   owner_idx - binary index of the current or last owner
//   num       - value to display (feeds seven_seg_controller num)
//   hold_done - current grant has met its minimum hold time
// master: requester/display side. slave: the arbiter.
interface seven_seg_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req;
    logic [16*NUM_REQ-1:0] data;
    logic                  lock;
    logic [NUM_REQ-1:0]    grant;
    logic [1:0]            owner_idx;
    logic [15:0]           num;
    logic                  hold_done;
    modport master (output req, data, lock, input grant, owner_idx, num, hold_done);
    modport slave  (input req, data, lock, output grant, owner_idx, num, hold_done);
endinterface

// File: rtl/seven_seg_arbiter.sv
// seven_seg_arbiter: round-robin sharing of one 4-digit seven-segment display.
//   clk50 - 50 MHz system clock
//   rst   - asynchronous active-high reset
//   bus   - seven_seg_arbiter_if.slave (req/data/lock in; grant/owner_idx/num/hold_done out)
// Optional: define SEVEN_SEG_ARB_PREEMPT_EN to let a rising req[0] take the
// display from any other owner (unless lock is high).
module seven_seg_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 25000000,
    parameter int CNT_W       = 25
) (
    input  logic               clk50,
    input  logic               rst,
    seven_seg_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HOLD = 2'd1;
    localparam logic [1:0] OPEN = 2'd2;

    logic [1:0]       state;
    logic [1:0]       ptr;
    logic [1:0]       owner;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      num_q;
    logic             hold_q;
    logic [1:0]       first_idx;
    logic             first_hit;
    logic [1:0]       next_idx;
    logic             next_hit;
    logic             preempt;

    assign bus.grant     = (state == IDLE) ? '0 : NUM_REQ'(1) << owner;
    assign bus.owner_idx = owner;
    assign bus.num       = num_q;
    assign bus.hold_done = hold_q;

    // Scanning offsets downward leaves the smallest matching offset as the winner.
    // first_*: first requester at or after ptr; next_*: first other requester after owner.
    always_comb begin
        first_idx = ptr;
        first_hit = 1'b0;
        next_idx  = owner;
        next_hit  = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req[(int'(ptr) + k) % NUM_REQ]) begin
                first_idx = 2'((int'(ptr) + k) % NUM_REQ);
                first_hit = 1'b1;
            end
        end
        for (int k = NUM_REQ - 1; k >= 1; k--) begin
            if (bus.req[(int'(owner) + k) % NUM_REQ]) begin
                next_idx = 2'((int'(owner) + k) % NUM_REQ);
                next_hit = 1'b1;
            end
        end
    end

`ifdef SEVEN_SEG_ARB_PREEMPT_EN
    logic req0_q;
    always_ff @(posedge clk50 or posedge rst) begin
        if (rst)
            req0_q <= 1'b0;
        else
            req0_q <= bus.req[0];
    end
    // Edge-triggered so a held req[0] cannot starve the others after its own turn.
    assign preempt = bus.req[0] & ~req0_q & ~bus.lock & (state != IDLE) & (owner != 2'd0);
`else
    assign preempt = 1'b0;
`endif

    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= 2'd0;
            owner  <= 2'd0;
            cnt    <= '0;
            hold_q <= 1'b0;
            num_q  <= 16'h0000;
        end else begin
            if (state != IDLE)
                num_q <= bus.data[{owner, 4'b0000} +: 16];
            if (preempt) begin
                owner  <= 2'd0;
                cnt    <= '0;
                hold_q <= 1'b0;
                state  <= HOLD;
            end else if (state == IDLE) begin
                if (first_hit) begin
                    owner <= first_idx;
                    cnt   <= '0;
                    state <= HOLD;
                end
            end else if (state == HOLD) begin
                // Lock does not pause the hold; it only blocks release from OPEN.
                if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                    hold_q <= 1'b1;
                    state  <= OPEN;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (!bus.lock) begin
                if (next_hit) begin
                    owner  <= next_idx;
                    ptr    <= 2'((int'(owner) + 1) % NUM_REQ);
                    cnt    <= '0;
                    hold_q <= 1'b0;
                    state  <= HOLD;
                end else if (!bus.req[owner]) begin
                    hold_q <= 1'b0;
                    state  <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_seven_seg_arbiter.sv
// tb_seven_seg_arbiter: directed scoreboard bench for seven_seg_arbiter (HOLD_CYCLES=4).
module tb_seven_seg_arbiter;
    localparam int N = 4;

    logic clk50 = 1'b0;
    logic rst   = 1'b1;

    seven_seg_arbiter_if #(.NUM_REQ(N)) bus();

    seven_seg_arbiter #(.NUM_REQ(N), .HOLD_CYCLES(4), .CNT_W(3)) dut (
        .clk50(clk50),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 clk50 = ~clk50;

    // care bits: [0] grant, [1] num, [2] hold_done, [3] owner_idx
    typedef struct {
        string       tag;
        logic [3:0]  care;
        logic [3:0]  g;
        logic [15:0] n;
        logic        h;
        logic [1:0]  o;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic push(input string tag, input logic [3:0] care, input logic [3:0] g,
                        input logic [15:0] n, input logic h, input logic [1:0] o);
        exp_t e;
        e.tag  = tag;
        e.care = care;
        e.g    = g;
        e.n    = n;
        e.h    = h;
        e.o    = o;
        sb.push_back(e);
    endtask

    task automatic compare();
        exp_t e;
        e = sb.pop_front();
        if (e.care[0]) begin
            checks++;
            assert (bus.grant === e.g) else begin
                errors++;
                $error("FAIL %s grant got %b want %b", e.tag, bus.grant, e.g);
            end
        end
        if (e.care[1]) begin
            checks++;
            assert (bus.num === e.n) else begin
                errors++;
                $error("FAIL %s num got %h want %h", e.tag, bus.num, e.n);
            end
        end
        if (e.care[2]) begin
            checks++;
            assert (bus.hold_done === e.h) else begin
                errors++;
                $error("FAIL %s hold_done got %b want %b", e.tag, bus.hold_done, e.h);
            end
        end
        if (e.care[3]) begin
            checks++;
            assert (bus.owner_idx === e.o) else begin
                errors++;
                $error("FAIL %s owner_idx got %0d want %0d", e.tag, bus.owner_idx, e.o);
            end
        end
    endtask

    task automatic drain();
        while (sb.size() > 0) begin
            @(negedge clk50);
            compare();
        end
    endtask

    task automatic do_reset();
        bus.req  = '0;
        bus.lock = 1'b0;
        bus.data = '0;
        rst      = 1'b1;
        @(negedge clk50);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req  = '0;
        bus.data = '0;
        bus.lock = 1'b0;
        repeat (2) @(negedge clk50);
        push("reset", 4'b1111, 4'b0000, 16'h0000, 1'b0, 2'd0);
        compare();

        // single requester: 1-cycle grant latency, 1 more for num, hold_done after 4
        rst = 1'b0;
        bus.req         = 4'b0001;
        bus.data[15:0]  = 16'h1234;
        push("t1_grant", 4'b1111, 4'b0001, 16'h0000, 1'b0, 2'd0);
        for (int k = 0; k < 3; k++)
            push("t1_hold", 4'b0111, 4'b0001, 16'h1234, 1'b0, 2'd0);
        push("t1_done", 4'b0111, 4'b0001, 16'h1234, 1'b1, 2'd0);
        drain();

        // all four requesting: each owner for 5 cycles, num one cycle behind
        do_reset();
        bus.req  = 4'b1111;
        bus.data = 64'h0003_0002_0001_0000;
        for (int k = 1; k <= 21; k++)
            push("t2_rr", (k >= 2) ? 4'b0111 : 4'b0101, 4'(1 << (((k - 1) / 5) % 4)),
                 16'(((k - 2) / 5) % 4), ((k - 1) % 5) == 4, 2'd0);
        drain();

        // owner drops req during hold: grant persists, then idle keeps last num
        do_reset();
        bus.data[31:16] = 16'hABCD;
        bus.req         = 4'b0010;
        push("t3_grant", 4'b1111, 4'b0010, 16'h0000, 1'b0, 2'd1);
        drain();
        bus.req = 4'b0000;
        for (int k = 0; k < 3; k++)
            push("t3_hold", 4'b0111, 4'b0010, 16'hABCD, 1'b0, 2'd0);
        push("t3_done", 4'b0111, 4'b0010, 16'hABCD, 1'b1, 2'd0);
        push("t3_idle", 4'b0011, 4'b0000, 16'hABCD, 1'b0, 2'd0);
        drain();
        bus.data[31:16] = 16'h5555;
        push("t3_keep", 4'b1011, 4'b0000, 16'hABCD, 1'b0, 2'd1);
        push("t3_keep", 4'b1011, 4'b0000, 16'hABCD, 1'b0, 2'd1);
        drain();

        // lock pins owner 2 against other requests; release rotates to 3
        do_reset();
        bus.data = 64'h3333_2222_1111_0000;
        bus.req  = 4'b0100;
        push("t4_grant", 4'b1001, 4'b0100, 16'h0000, 1'b0, 2'd2);
        drain();
        bus.lock = 1'b1;
        bus.req  = 4'b1011;
        for (int k = 0; k < 20; k++)
            push("t4_lock", 4'b0111, 4'b0100, 16'h2222, k >= 3, 2'd2);
        drain();
        bus.lock = 1'b0;
        push("t4_release", 4'b1101, 4'b1000, 16'h0000, 1'b0, 2'd3);
        drain();

        // asynchronous reset in the middle of a hold
        do_reset();
        bus.data[63:48] = 16'h3333;
        bus.req         = 4'b1000;
        push("t5_grant", 4'b1001, 4'b1000, 16'h0000, 1'b0, 2'd3);
        push("t5_hold", 4'b0011, 4'b1000, 16'h3333, 1'b0, 2'd3);
        drain();
        #2 rst = 1'b1;
        #1;
        push("t5_rst", 4'b1111, 4'b0000, 16'h0000, 1'b0, 2'd0);
        compare();
        @(negedge clk50);
        rst     = 1'b0;
        bus.req = 4'b0001;
        push("t5_after", 4'b1101, 4'b0001, 16'h0000, 1'b0, 2'd0);
        drain();

`ifdef SEVEN_SEG_ARB_PREEMPT_EN
        do_reset();
        bus.req = 4'b0100;
        push("t6_grant", 4'b1001, 4'b0100, 16'h0000, 1'b0, 2'd2);
        drain();
        bus.req = 4'b0101;
        push("t6_preempt", 4'b1101, 4'b0001, 16'h0000, 1'b0, 2'd0);
        drain();
        do_reset();
        bus.req = 4'b0100;
        push("t6_grant_l", 4'b1001, 4'b0100, 16'h0000, 1'b0, 2'd2);
        drain();
        bus.lock = 1'b1;
        bus.req  = 4'b0101;
        push("t6_locked", 4'b1001, 4'b0100, 16'h0000, 1'b0, 2'd2);
        drain();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
